// File: rtl/stall_flush_ctrl.sv
// Pipeline hazard controller: load-use, branch redirect and data-memory wait handling with bus timeout.
// Stall/flush outputs are combinational (0 cycles); err_timeout and perf counters are registered.
module stall_flush_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  D_rs1_addr,
  input  logic [4:0]  D_rs2_addr,
  input  logic        D_uses_rs1,
  input  logic        D_uses_rs2,
  input  logic [4:0]  E_rd_addr,
  input  logic        E_mem_read,
  input  logic        E_pc_redirect,
  input  logic        M_dmem_req,
  input  logic        M_dmem_ready,
  output logic        F_stall,
  output logic        D_stall,
  output logic        E_stall,
  output logic        M_stall,
  output logic        D_flush,
  output logic        E_flush,
  output logic        W_flush,
  output logic        err_timeout,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_TIMEOUT  = 2'd2
  } state_e;

  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        err_timeout_q, err_timeout_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
  logic [31:0] perf_flush_cnt_q, perf_flush_cnt_d;
  logic        load_use;
  logic        mem_wait;

  assign load_use = E_mem_read & (E_rd_addr != 5'd0) &
                    ((D_uses_rs1 & (E_rd_addr == D_rs1_addr)) |
                     (D_uses_rs2 & (E_rd_addr == D_rs2_addr)));
  assign mem_wait = M_dmem_req & ~M_dmem_ready;

  // A held Execute stage defers any redirect or load-use until memory answers.
  always_comb begin
    F_stall = 1'b0;
    D_stall = 1'b0;
    E_stall = 1'b0;
    M_stall = 1'b0;
    D_flush = 1'b0;
    E_flush = 1'b0;
    W_flush = 1'b0;
    if (!rst_n) begin
      D_flush = 1'b1;
      E_flush = 1'b1;
      W_flush = 1'b1;
    end else if ((state_q == ST_TIMEOUT) || mem_wait) begin
      F_stall = 1'b1;
      D_stall = 1'b1;
      E_stall = 1'b1;
      M_stall = 1'b1;
      W_flush = 1'b1;
    end else if (E_pc_redirect) begin
      D_flush = 1'b1;
      E_flush = 1'b1;
    end else if (load_use) begin
      F_stall = 1'b1;
      D_stall = 1'b1;
      E_flush = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = 16'd0;
    if (mem_wait) begin
      wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q : wait_cnt_q + 16'd1;
    end
    case (state_q)
      ST_RUN: begin
        if (mem_wait) state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (!mem_wait) begin
          state_d = ST_RUN;
        end else if ((wait_cnt_q + 16'd1) == WAIT_LIMIT) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_TIMEOUT: state_d = ST_TIMEOUT;
      default:    state_d = ST_RUN;
    endcase
    err_timeout_d    = err_timeout_q | (state_d == ST_TIMEOUT);
    perf_stall_cnt_d = perf_stall_cnt_q + {31'd0, F_stall & (state_q != ST_TIMEOUT)};
    perf_flush_cnt_d = perf_flush_cnt_q + {31'd0, D_flush | E_flush};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_RUN;
      wait_cnt_q       <= 16'd0;
      err_timeout_q    <= 1'b0;
      perf_stall_cnt_q <= 32'd0;
      perf_flush_cnt_q <= 32'd0;
    end else begin
      state_q          <= state_d;
      wait_cnt_q       <= wait_cnt_d;
      err_timeout_q    <= err_timeout_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
      perf_flush_cnt_q <= perf_flush_cnt_d;
    end
  end

  assign err_timeout    = err_timeout_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
  assign perf_flush_cnt = perf_flush_cnt_q;

endmodule
